// File: rtl/seq_calc_engine.sv
// seq_calc_engine: sign-magnitude accumulating calculator.
// Operands arrive over a valid/ready handshake. Add/sub finish in one cycle,
// multiply is shift-add (one multiplier bit per cycle, LSB first), and divide
// is restoring division (one quotient bit per cycle, MSB first).
// Build option: define SEQ_CALC_SAT_EN to clamp overflowed results to full
// scale instead of wrapping.
`timescale 1ns/1ps
module seq_calc_engine #(
   parameter int ACC_W     = 7,
   parameter int OPND_W    = 2,
   parameter int MAX_STEPS = 5
) (
   input  logic              Clk,
   input  logic              Reset,
   input  logic              clear,
   input  logic              op_valid,
   output logic              op_ready,
   input  logic [1:0]        op_code,
   input  logic              opnd_sign,
   input  logic [OPND_W-1:0] opnd_mag,
   output logic              acc_sign,
   output logic [ACC_W-1:0]  acc_mag,
   output logic              result_valid,
   output logic              busy,
   output logic              done,
   output logic              flag_zero,
   output logic              flag_neg,
   output logic              flag_ovf,
   output logic              flag_err,
   output logic [3:0]        step_cnt
);

   localparam int P_W  = ACC_W + OPND_W;
   localparam int IT_W = $clog2(P_W + 1);

`ifdef SEQ_CALC_SAT_EN
   localparam bit SAT_EN = 1'b1;
`else
   localparam bit SAT_EN = 1'b0;
`endif

   localparam logic [1:0]      OP_SUB    = 2'b01;
   localparam logic [1:0]      OP_MUL    = 2'b10;
   localparam logic [1:0]      OP_DIV    = 2'b11;
   localparam logic [3:0]      LAST_STEP = 4'(MAX_STEPS);
   localparam logic [IT_W-1:0] MUL_LAST  = IT_W'(OPND_W - 1);
   localparam logic [IT_W-1:0] DIV_LAST  = IT_W'(ACC_W - 1);

   typedef enum logic [2:0] {
      S_LOAD, S_READY, S_MUL, S_DIV, S_DONE, S_ERR
   } state_t;

   // Overflow policy: wrap keeps the low bits, saturation clamps to full scale.
   function automatic logic [ACC_W-1:0] ovf_fix(input logic [ACC_W-1:0] low,
                                                input logic ovf);
      ovf_fix = (SAT_EN && ovf) ? {ACC_W{1'b1}} : low;
   endfunction

   // A zero magnitude is always reported as positive.
   function automatic logic zero_norm(input logic sign,
                                      input logic [ACC_W-1:0] mag);
      zero_norm = sign & (|mag);
   endfunction

   // Control / architectural state
   state_t             state_q, state_d;
   logic               acc_sign_q, acc_sign_d;
   logic [ACC_W-1:0]   acc_mag_q, acc_mag_d;
   logic               rv_q, rv_d;
   logic               ovf_q, ovf_d;
   logic               err_q, err_d;
   logic [3:0]         step_q, step_d;

   // Multi-cycle datapath state (loaded at accept, no reset needed)
   logic               res_sign_q;
   logic [P_W-1:0]     prod_q, mcand_q;
   logic [OPND_W-1:0]  mplier_q;
   logic [OPND_W-1:0]  rem_q;
   logic [ACC_W-1:0]   quo_q;
   logic [OPND_W-1:0]  dvsr_q;
   logic [IT_W-1:0]    it_q;

   logic               accept;
   logic [3:0]         step_inc;

   // Add/sub result
   logic               eff_sign;
   logic [ACC_W-1:0]   opnd_ext;
   logic [ACC_W:0]     as_sum;
   logic               as_sign;
   logic               as_ovf;

   // Iteration results
   logic [P_W-1:0]     prod_nxt;
   logic               mul_ovf;
   logic [OPND_W:0]    rem_sh;
   logic               rem_ge;
   logic [OPND_W-1:0]  rem_nxt;
   logic [ACC_W-1:0]   quo_nxt;

   assign op_ready     = (state_q == S_LOAD) || (state_q == S_READY);
   assign busy         = (state_q == S_MUL) || (state_q == S_DIV);
   assign done         = (state_q == S_DONE);
   assign accept       = op_valid && op_ready;
   assign step_inc     = step_q + 4'd1;

   assign acc_sign     = acc_sign_q;
   assign acc_mag      = acc_mag_q;
   assign result_valid = rv_q;
   assign flag_zero    = (acc_mag_q == '0);
   assign flag_neg     = acc_sign_q;
   assign flag_ovf     = ovf_q;
   assign flag_err     = err_q;
   assign step_cnt     = step_q;

   // Single-cycle sign-magnitude add; sub flips the operand sign first.
   always_comb begin
      eff_sign = opnd_sign ^ (op_code == OP_SUB);
      opnd_ext = ACC_W'(opnd_mag);
      if (eff_sign == acc_sign_q) begin
         as_sum  = {1'b0, acc_mag_q} + {1'b0, opnd_ext};
         as_sign = acc_sign_q;
      end else if (acc_mag_q >= opnd_ext) begin
         as_sum  = {1'b0, acc_mag_q - opnd_ext};
         as_sign = acc_sign_q;
      end else begin
         as_sum  = {1'b0, opnd_ext - acc_mag_q};
         as_sign = eff_sign;
      end
      as_ovf = as_sum[ACC_W];
   end

   // One shift-add multiply step and one restoring divide step.
   always_comb begin
      prod_nxt = prod_q + (mplier_q[0] ? mcand_q : '0);
      mul_ovf  = |prod_nxt[P_W-1:ACC_W];
      rem_sh   = {rem_q, quo_q[ACC_W-1]};
      rem_ge   = (rem_sh >= {1'b0, dvsr_q});
      rem_nxt  = rem_ge ? OPND_W'(rem_sh - {1'b0, dvsr_q}) : rem_sh[OPND_W-1:0];
      quo_nxt  = {quo_q[ACC_W-2:0], rem_ge};
   end

   // Next-state and result commit logic.
   always_comb begin
      state_d    = state_q;
      acc_sign_d = acc_sign_q;
      acc_mag_d  = acc_mag_q;
      rv_d       = 1'b0;
      ovf_d      = ovf_q;
      err_d      = err_q;
      step_d     = step_q;
      unique case (state_q)
         S_LOAD: begin
            if (accept) begin
               step_d     = step_inc;
               acc_mag_d  = ACC_W'(opnd_mag);
               acc_sign_d = opnd_sign & (|opnd_mag);
               ovf_d      = 1'b0;
               rv_d       = 1'b1;
               state_d    = (step_inc == LAST_STEP) ? S_DONE : S_READY;
            end
         end
         S_READY: begin
            if (accept) begin
               step_d = step_inc;
               if (op_code == OP_MUL) begin
                  state_d = S_MUL;
               end else if (op_code == OP_DIV) begin
                  if (opnd_mag == '0) begin
                     err_d   = 1'b1;
                     state_d = S_ERR;
                  end else begin
                     state_d = S_DIV;
                  end
               end else begin
                  acc_mag_d  = ovf_fix(as_sum[ACC_W-1:0], as_ovf);
                  acc_sign_d = zero_norm(as_sign, acc_mag_d);
                  ovf_d      = as_ovf;
                  rv_d       = 1'b1;
                  state_d    = (step_inc == LAST_STEP) ? S_DONE : S_READY;
               end
            end
         end
         S_MUL: begin
            if (it_q == MUL_LAST) begin
               acc_mag_d  = ovf_fix(prod_nxt[ACC_W-1:0], mul_ovf);
               acc_sign_d = zero_norm(res_sign_q, acc_mag_d);
               ovf_d      = mul_ovf;
               rv_d       = 1'b1;
               state_d    = (step_q == LAST_STEP) ? S_DONE : S_READY;
            end
         end
         S_DIV: begin
            if (it_q == DIV_LAST) begin
               acc_mag_d  = quo_nxt;
               acc_sign_d = zero_norm(res_sign_q, quo_nxt);
               ovf_d      = 1'b0;
               rv_d       = 1'b1;
               state_d    = (step_q == LAST_STEP) ? S_DONE : S_READY;
            end
         end
         S_DONE:  state_d = S_DONE;
         S_ERR:   state_d = S_ERR;
         default: state_d = S_LOAD;
      endcase
   end

   // Control registers: async reset, then synchronous clear, then update.
   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         state_q    <= S_LOAD;
         acc_sign_q <= 1'b0;
         acc_mag_q  <= '0;
         rv_q       <= 1'b0;
         ovf_q      <= 1'b0;
         err_q      <= 1'b0;
         step_q     <= 4'd0;
      end else if (clear) begin
         state_q    <= S_LOAD;
         acc_sign_q <= 1'b0;
         acc_mag_q  <= '0;
         rv_q       <= 1'b0;
         ovf_q      <= 1'b0;
         err_q      <= 1'b0;
         step_q     <= 4'd0;
      end else begin
         state_q    <= state_d;
         acc_sign_q <= acc_sign_d;
         acc_mag_q  <= acc_mag_d;
         rv_q       <= rv_d;
         ovf_q      <= ovf_d;
         err_q      <= err_d;
         step_q     <= step_d;
      end
   end

   // Iteration registers: capture operands at accept, step while busy.
   always_ff @(posedge Clk) begin
      if (accept) begin
         res_sign_q <= acc_sign_q ^ opnd_sign;
         prod_q     <= '0;
         mcand_q    <= P_W'(acc_mag_q);
         mplier_q   <= opnd_mag;
         rem_q      <= '0;
         quo_q      <= acc_mag_q;
         dvsr_q     <= opnd_mag;
         it_q       <= '0;
      end else if (busy) begin
         prod_q     <= prod_nxt;
         mcand_q    <= mcand_q << 1;
         mplier_q   <= mplier_q >> 1;
         rem_q      <= rem_nxt;
         quo_q      <= quo_nxt;
         it_q       <= it_q + IT_W'(1);
      end
   end

endmodule

// File: tb/tb_seq_calc_engine.sv
`timescale 1ns/1ps
module tb_seq_calc_engine;

   logic       Clk;
   logic       Reset;
   logic       clear;
   logic       op_valid;
   logic       op_ready;
   logic [1:0] op_code;
   logic       opnd_sign;
   logic [1:0] opnd_mag;
   logic       acc_sign;
   logic [6:0] acc_mag;
   logic       result_valid;
   logic       busy;
   logic       done;
   logic       flag_zero;
   logic       flag_neg;
   logic       flag_ovf;
   logic       flag_err;
   logic [3:0] step_cnt;

   int n_chk  = 0;
   int n_pass = 0;

   seq_calc_engine dut (
      .Clk          (Clk),
      .Reset        (Reset),
      .clear        (clear),
      .op_valid     (op_valid),
      .op_ready     (op_ready),
      .op_code      (op_code),
      .opnd_sign    (opnd_sign),
      .opnd_mag     (opnd_mag),
      .acc_sign     (acc_sign),
      .acc_mag      (acc_mag),
      .result_valid (result_valid),
      .busy         (busy),
      .done         (done),
      .flag_zero    (flag_zero),
      .flag_neg     (flag_neg),
      .flag_ovf     (flag_ovf),
      .flag_err     (flag_err),
      .step_cnt     (step_cnt)
   );

   initial begin
      Clk = 1'b0;
      forever #5 Clk = ~Clk;
   end

   task automatic chk(input string tag, input int got, input int exp);
      n_chk++;
      if (got == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
   endtask

   // Accumulator as sign*128 + magnitude, e.g. -4 -> 132.
   function automatic int acc_val();
      return int'({acc_sign, acc_mag});
   endfunction

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   task automatic do_clear();
      clear = 1'b1;
      tick();
      clear = 1'b0;
   endtask

   // Present one operand, then scramble inputs and wait for result_valid.
   task automatic run_op(input logic [1:0] code, input logic s, input logic [1:0] m,
                         output int lat, output int bsy);
      op_code   = code;
      opnd_sign = s;
      opnd_mag  = m;
      op_valid  = 1'b1;
      tick();
      op_valid  = 1'b0;
      op_code   = ~code;
      opnd_sign = ~s;
      opnd_mag  = ~m;
      lat = 1;
      bsy = 0;
      while (!result_valid && lat < 40) begin
         if (busy) bsy++;
         tick();
         lat++;
      end
      if (!result_valid) chk("rv_timeout", int'(result_valid), 1);
   endtask

   initial begin
      int lat, bsy, pulses;
      Reset = 1'b0; clear = 1'b0; op_valid = 1'b0;
      op_code = 2'b00; opnd_sign = 1'b0; opnd_mag = 2'd0;
      #12;
      chk("rst_ready", int'(op_ready), 1);
      chk("rst_zero",  int'(flag_zero), 1);
      chk("rst_acc",   acc_val(), 0);
      chk("rst_step",  int'(step_cnt), 0);
      chk("rst_done",  int'(done), 0);
      tick();
      Reset = 1'b1;
      tick();

      // Load +3, add -2, sub +3, mul -3, add +0
      run_op(2'b00, 1'b0, 2'd3, lat, bsy);
      chk("t1_load", acc_val(), 3);
      chk("t1_load_lat", lat, 1);
      chk("t1_step1", int'(step_cnt), 1);
      run_op(2'b00, 1'b1, 2'd2, lat, bsy);
      chk("t1_add", acc_val(), 1);
      run_op(2'b01, 1'b0, 2'd3, lat, bsy);
      chk("t1_sub", acc_val(), 128 + 2);
      chk("t1_neg", int'(flag_neg), 1);
      run_op(2'b10, 1'b1, 2'd3, lat, bsy);
      chk("t1_mul", acc_val(), 6);
      chk("t1_mul_lat", lat, 3);
      run_op(2'b00, 1'b0, 2'd0, lat, bsy);
      chk("t1_add0", acc_val(), 6);
      chk("t1_done", int'(done), 1);
      chk("t1_ready", int'(op_ready), 0);
      chk("t1_step5", int'(step_cnt), 5);
      tick();
      chk("t1_rv_pulse", int'(result_valid), 0);
      op_valid = 1'b1; op_code = 2'b00; opnd_sign = 1'b0; opnd_mag = 2'd1;
      pulses = 0;
      for (int i = 0; i < 4; i++) begin
         tick();
         if (result_valid) pulses++;
      end
      op_valid = 1'b0;
      chk("t1_ign_rv", pulses, 0);
      chk("t1_ign_acc", acc_val(), 6);
      chk("t1_ign_step", int'(step_cnt), 5);
      do_clear();
      chk("t1_clr_ready", int'(op_ready), 1);
      chk("t1_clr_done", int'(done), 0);
      chk("t1_clr_acc", acc_val(), 0);

      // Load +3, mul +3, div -2
      run_op(2'b00, 1'b0, 2'd3, lat, bsy);
      run_op(2'b10, 1'b0, 2'd3, lat, bsy);
      chk("t2_mul", acc_val(), 9);
      chk("t2_mul_lat", lat, 3);
      chk("t2_mul_busy", bsy, 2);
      run_op(2'b11, 1'b1, 2'd2, lat, bsy);
      chk("t2_div", acc_val(), 128 + 4);
      chk("t2_div_lat", lat, 8);
      chk("t2_div_busy", bsy, 7);
      chk("t2_div_ovf", int'(flag_ovf), 0);
      do_clear();

      // Load -3, div +0
      run_op(2'b00, 1'b1, 2'd3, lat, bsy);
      chk("t3_load", acc_val(), 128 + 3);
      op_valid = 1'b1; op_code = 2'b11; opnd_sign = 1'b0; opnd_mag = 2'd0;
      tick();
      op_valid = 1'b0;
      chk("t3_err", int'(flag_err), 1);
      chk("t3_rv", int'(result_valid), 0);
      chk("t3_acc", acc_val(), 128 + 3);
      chk("t3_ready", int'(op_ready), 0);
      chk("t3_step", int'(step_cnt), 2);
      tick();
      chk("t3_err_hold", int'(flag_err), 1);
      do_clear();
      chk("t3_clr_err", int'(flag_err), 0);
      chk("t3_clr_acc", acc_val(), 0);
      chk("t3_clr_ready", int'(op_ready), 1);

      // Overflow: 3*3*3*3 = 81, *3 = 243
      run_op(2'b00, 1'b0, 2'd3, lat, bsy);
      run_op(2'b10, 1'b0, 2'd3, lat, bsy);
      run_op(2'b10, 1'b0, 2'd3, lat, bsy);
      run_op(2'b10, 1'b0, 2'd3, lat, bsy);
      chk("t4_81", acc_val(), 81);
      chk("t4_no_ovf", int'(flag_ovf), 0);
      run_op(2'b10, 1'b0, 2'd3, lat, bsy);
`ifdef SEQ_CALC_SAT_EN
      chk("t4_sat", acc_val(), 127);
`else
      chk("t4_wrap", acc_val(), 115);
`endif
      chk("t4_ovf", int'(flag_ovf), 1);
      chk("t4_done", int'(done), 1);
      do_clear();
      chk("t4_clr_ovf", int'(flag_ovf), 0);

      // Zero normalisation: -0 load, then +2 - 2
      run_op(2'b00, 1'b1, 2'd0, lat, bsy);
      chk("t5_negzero", acc_val(), 0);
      do_clear();
      run_op(2'b00, 1'b0, 2'd2, lat, bsy);
      run_op(2'b01, 1'b0, 2'd2, lat, bsy);
      chk("t5_acc", acc_val(), 0);
      chk("t5_zero", int'(flag_zero), 1);
      chk("t5_neg", int'(flag_neg), 0);
      do_clear();

      // Reset in the middle of a divide
      run_op(2'b00, 1'b0, 2'd3, lat, bsy);
      run_op(2'b10, 1'b0, 2'd3, lat, bsy);
      run_op(2'b10, 1'b0, 2'd3, lat, bsy);
      run_op(2'b10, 1'b0, 2'd3, lat, bsy);
      op_valid = 1'b1; op_code = 2'b11; opnd_sign = 1'b0; opnd_mag = 2'd3;
      tick();
      op_valid = 1'b0;
      tick(); tick(); tick();
      chk("t6_busy_pre", int'(busy), 1);
      Reset = 1'b0;
      #1;
      chk("t6_rst_busy", int'(busy), 0);
      chk("t6_rst_ready", int'(op_ready), 1);
      chk("t6_rst_acc", acc_val(), 0);
      chk("t6_rst_zero", int'(flag_zero), 1);
      chk("t6_rst_step", int'(step_cnt), 0);
      chk("t6_rst_rv", int'(result_valid), 0);
      tick();
      Reset = 1'b1;
      pulses = 0;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (result_valid) pulses++;
      end
      chk("t6_no_stray_rv", pulses, 0);
      chk("t6_ready", int'(op_ready), 1);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
